serial_digit_comparator: RTL and testbench



---
 rtl/serial_digit_comparator_if.sv | 44 ++++
 rtl/serial_digit_comparator.sv | 186 ++++++++++++++++++
 tb/tb_serial_digit_comparator.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/serial_digit_comparator_if.sv
// -----------------------------------------------------------------------------
// serial_digit_comparator_if
//
// Purpose : Bundles the request/response signals of serial_digit_comparator.
//           The requester drives start/operands/mode; the comparator answers
//           with busy/done and the eq/gt/lt result flags.
//
// Signals :
//   start  requester -> comparator  request a compare (sampled only when idle)
//   a, b   requester -> comparator  WIDTH-bit unsigned operands
//   mode   requester -> comparator  0 = equality only, 1 = unsigned magnitude
//   busy   comparator -> requester  high while slices are being compared
//   done   comparator -> requester  one-cycle pulse when results become valid
//   eq     comparator -> requester  A == B
//   gt     comparator -> requester  A >  B (always 0 in equality mode)
//   lt     comparator -> requester  A <  B (always 0 in equality mode)
//
// Modports: master = requester side, slave = comparator side.
// -----------------------------------------------------------------------------
interface serial_digit_comparator_if #(
    parameter int WIDTH = 8
) ();

    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             mode;
    logic             busy;
    logic             done;
    logic             eq;
    logic             gt;
    logic             lt;

    modport master (
        output start, a, b, mode,
        input  busy, done, eq, gt, lt
    );

    modport slave (
        input  start, a, b, mode,
        output busy, done, eq, gt, lt
    );

endinterface : serial_digit_comparator_if

// File: rtl/serial_digit_comparator.sv
// -----------------------------------------------------------------------------
// serial_digit_comparator
//
// Purpose : Compares two WIDTH-bit unsigned words one DIGIT-bit slice per
//           clock, most significant slice first. Supports pure equality and
//           unsigned magnitude comparison, with optional early termination on
//           the first mismatching slice (EARLY = 1).
//
// Parameters:
//   WIDTH  operand width in bits (multiple of DIGIT)
//   DIGIT  bits compared per clock (>= 1)
//   EARLY  1 = finish at the first mismatching slice, 0 = always scan all slices
//
// Ports:
//   clk    rising-edge clock
//   rst    synchronous, active-high reset
//   bus    serial_digit_comparator_if.slave
//            start/a/b/mode in, busy/done/eq/gt/lt out
//
// Timing (N = WIDTH/DIGIT, edges counted including the edge accepting start):
//   busy is high for one cycle per processed slice, done pulses for one cycle
//   after N+1 edges (or k+1 edges when EARLY = 1 and slice k mismatches first).
//   Minimum start-to-start period is N+2 cycles.
// -----------------------------------------------------------------------------
module serial_digit_comparator #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 2,
    parameter bit EARLY = 1'b1
) (
    input  logic                        clk,
    input  logic                        rst,
    serial_digit_comparator_if.slave    bus
);

    localparam int N    = WIDTH / DIGIT;
    localparam int IDXW = $clog2(N + 1);

    if ((DIGIT < 1) || (WIDTH % DIGIT != 0)) begin : g_bad_params
        $error("serial_digit_comparator: WIDTH must be a non-zero multiple of DIGIT");
    end

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_t;

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    state_t            state_q, state_d;
    logic [IDXW-1:0]   idx_q,   idx_d;
    logic [WIDTH-1:0]  a_q,     a_d;
    logic [WIDTH-1:0]  b_q,     b_d;
    logic              mode_q,  mode_d;
    logic              mism_q,  mism_d;   // a mismatching slice has been recorded
    logic              busy_q,  busy_d;
    logic              done_q,  done_d;
    logic              eq_q,    eq_d;
    logic              gt_q,    gt_d;
    logic              lt_q,    lt_d;

    // Current slice of each captured operand.
    logic [DIGIT-1:0]  sa;
    logic [DIGIT-1:0]  sb;

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    // NOTE: every signal written here gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        a_d     = a_q;
        b_d     = b_q;
        mode_d  = mode_q;
        mism_d  = mism_q;
        eq_d    = eq_q;
        gt_d    = gt_q;
        lt_d    = lt_q;

        sa = DIGIT'(a_q >> (int'(idx_q) * DIGIT));
        sb = DIGIT'(b_q >> (int'(idx_q) * DIGIT));

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    a_d     = bus.a;
                    b_d     = bus.b;
                    mode_d  = bus.mode;
                    idx_d   = IDXW'(N - 1);
                    mism_d  = 1'b0;
                    eq_d    = 1'b0;
                    gt_d    = 1'b0;
                    lt_d    = 1'b0;
                    state_d = ST_RUN;
                end
            end

            ST_RUN: begin
                // Only the most significant mismatch decides the result;
                // later slices are ignored once mism_q is set.
                if ((sa != sb) && !mism_q) begin
                    mism_d = 1'b1;
                    gt_d   = mode_q && (sa > sb);
                    lt_d   = mode_q && (sa < sb);
                    if (EARLY) begin
                        state_d = ST_DONE;
                    end
                end

                if (idx_q == '0) begin
                    // mism_d includes a mismatch found on this last slice.
                    if (!mism_d) begin
                        eq_d = 1'b1;
                    end
                    state_d = ST_DONE;
                end else if (state_d == ST_RUN) begin
                    idx_d = idx_q - 1'b1;
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Status flags are registered copies of the next state, so they are
        // glitch-free and line up exactly with the state they describe.
        busy_d = (state_d == ST_RUN);
        done_d = (state_d == ST_DONE);
    end

    // -------------------------------------------------------------------------
    // Control and result registers
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples its pre-edge value regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            mism_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            eq_q    <= 1'b0;
            gt_q    <= 1'b0;
            lt_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            mism_q  <= mism_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            eq_q    <= eq_d;
            gt_q    <= gt_d;
            lt_q    <= lt_d;
        end
    end

    // -------------------------------------------------------------------------
    // Operand captures
    // -------------------------------------------------------------------------
    // NOTE: the operand/mode registers are pure datapath and carry no reset;
    // they are always loaded on start acceptance before anything reads them.
    always_ff @(posedge clk) begin
        a_q    <= a_d;
        b_q    <= b_d;
        mode_q <= mode_d;
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.eq   = eq_q;
    assign bus.gt   = gt_q;
    assign bus.lt   = lt_q;

endmodule : serial_digit_comparator

// File: tb/tb_serial_digit_comparator.sv
// -----------------------------------------------------------------------------
// tb_serial_digit_comparator
//
// Three comparator instances share clk/rst:
//   dut 0 : WIDTH=8, DIGIT=2, EARLY=1
//   dut 1 : WIDTH=8, DIGIT=2, EARLY=0
//   dut 2 : WIDTH=4, DIGIT=1, EARLY=1
// A table of directed vectors with hand-computed latency and flags is applied
// in a loop, followed by hand-written sequences for hold, back-to-back start
// and mid-compare reset.
// -----------------------------------------------------------------------------
module tb_serial_digit_comparator;

    logic clk;
    logic rst;

    int n_tests;
    int n_fail;

    serial_digit_comparator_if #(.WIDTH(8)) if8  ();
    serial_digit_comparator_if #(.WIDTH(8)) if8n ();
    serial_digit_comparator_if #(.WIDTH(4)) if4  ();

    serial_digit_comparator #(.WIDTH(8), .DIGIT(2), .EARLY(1'b1)) u_dut8 (
        .clk (clk),
        .rst (rst),
        .bus (if8)
    );

    serial_digit_comparator #(.WIDTH(8), .DIGIT(2), .EARLY(1'b0)) u_dut8n (
        .clk (clk),
        .rst (rst),
        .bus (if8n)
    );

    serial_digit_comparator #(.WIDTH(4), .DIGIT(1), .EARLY(1'b1)) u_dut4 (
        .clk (clk),
        .rst (rst),
        .bus (if4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int         which;
        logic [7:0] a;
        logic [7:0] b;
        logic       mode;
        int         lat;    // edges from (and including) the accepting edge to done
        logic       eq;
        logic       gt;
        logic       lt;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input int which, input logic st, input logic [7:0] av,
                         input logic [7:0] bv, input logic md);
        case (which)
            0: begin if8.start  = st; if8.a  = av;      if8.b  = bv;      if8.mode  = md; end
            1: begin if8n.start = st; if8n.a = av;      if8n.b = bv;      if8n.mode = md; end
            default: begin if4.start = st; if4.a = av[3:0]; if4.b = bv[3:0]; if4.mode = md; end
        endcase
    endtask

    task automatic sample(input int which, output logic bz, output logic dn,
                          output logic e, output logic g, output logic l);
        case (which)
            0: begin bz = if8.busy;  dn = if8.done;  e = if8.eq;  g = if8.gt;  l = if8.lt;  end
            1: begin bz = if8n.busy; dn = if8n.done; e = if8n.eq; g = if8n.gt; l = if8n.lt; end
            default: begin bz = if4.busy; dn = if4.done; e = if4.eq; g = if4.gt; l = if4.lt; end
        endcase
    endtask

    // Step one clock and sample 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulse start for one cycle, then count edges until done (bounded).
    task automatic run_cmp(input vec_t v, input string tag);
        logic bz, dn, e, g, l;
        int   edges;
        int   busy_cnt;
        @(negedge clk);
        drive(v.which, 1'b1, v.a, v.b, v.mode);
        tick();
        drive(v.which, 1'b0, 8'h00, 8'h00, 1'b0);
        edges    = 1;
        busy_cnt = 0;
        sample(v.which, bz, dn, e, g, l);
        while (!dn && edges < 40) begin
            if (bz) busy_cnt++;
            tick();
            edges++;
            sample(v.which, bz, dn, e, g, l);
        end
        check({tag, "_latency"}, edges, v.lat);
        check({tag, "_busy_cycles"}, busy_cnt, v.lat - 1);
        check({tag, "_flags_eq_gt_lt"}, {e, g, l}, {v.eq, v.gt, v.lt});
        check({tag, "_busy_in_done"}, bz, 1'b0);
        tick();
        sample(v.which, bz, dn, e, g, l);
        check({tag, "_done_one_cycle"}, {bz, dn}, 2'b00);
        check({tag, "_flags_held"}, {e, g, l}, {v.eq, v.gt, v.lt});
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic bz, dn, e, g, l;
        int   edges;
        logic saw_done;

        n_tests = 0;
        n_fail  = 0;

        //           which a      b      mode lat eq gt lt
        // dut 0: WIDTH=8 DIGIT=2 EARLY=1 (4 slices)
        vecs.push_back(vec_t'{0, 8'hA5, 8'hA5, 1'b1, 5, 1'b1, 1'b0, 1'b0});
        vecs.push_back(vec_t'{0, 8'h80, 8'h7F, 1'b1, 2, 1'b0, 1'b1, 1'b0});
        vecs.push_back(vec_t'{0, 8'h12, 8'h13, 1'b0, 5, 1'b0, 1'b0, 1'b0});
        vecs.push_back(vec_t'{0, 8'h12, 8'h13, 1'b1, 5, 1'b0, 1'b0, 1'b1});
        vecs.push_back(vec_t'{0, 8'h00, 8'hFF, 1'b0, 2, 1'b0, 1'b0, 1'b0});
        vecs.push_back(vec_t'{0, 8'h3C, 8'h34, 1'b1, 4, 1'b0, 1'b1, 1'b0});
        vecs.push_back(vec_t'{0, 8'h5A, 8'h5A, 1'b0, 5, 1'b1, 1'b0, 1'b0});
        vecs.push_back(vec_t'{0, 8'hFF, 8'hFF, 1'b1, 5, 1'b1, 1'b0, 1'b0});
        vecs.push_back(vec_t'{0, 8'h01, 8'h00, 1'b1, 5, 1'b0, 1'b1, 1'b0});
        vecs.push_back(vec_t'{0, 8'h40, 8'hC0, 1'b1, 2, 1'b0, 1'b0, 1'b1});
        // dut 1: WIDTH=8 DIGIT=2 EARLY=0 -- always 5 edges, MSB mismatch wins
        vecs.push_back(vec_t'{1, 8'h40, 8'h3F, 1'b1, 5, 1'b0, 1'b1, 1'b0});
        vecs.push_back(vec_t'{1, 8'h3F, 8'h40, 1'b1, 5, 1'b0, 1'b0, 1'b1});
        vecs.push_back(vec_t'{1, 8'hA5, 8'hA5, 1'b1, 5, 1'b1, 1'b0, 1'b0});
        vecs.push_back(vec_t'{1, 8'h80, 8'h00, 1'b0, 5, 1'b0, 1'b0, 1'b0});
        // dut 2: WIDTH=4 DIGIT=1 EARLY=1 (4 slices)
        vecs.push_back(vec_t'{2, 8'h03, 8'h09, 1'b1, 2, 1'b0, 1'b0, 1'b1});
        vecs.push_back(vec_t'{2, 8'h09, 8'h09, 1'b1, 5, 1'b1, 1'b0, 1'b0});
        vecs.push_back(vec_t'{2, 8'h06, 8'h07, 1'b1, 5, 1'b0, 1'b0, 1'b1});
        vecs.push_back(vec_t'{2, 8'h0C, 8'h04, 1'b1, 2, 1'b0, 1'b1, 1'b0});

        // ---------------- reset ----------------
        rst = 1'b1;
        for (int w = 0; w < 3; w++) drive(w, 1'b0, 8'h00, 8'h00, 1'b0);
        tick();
        tick();
        for (int w = 0; w < 3; w++) begin
            sample(w, bz, dn, e, g, l);
            check($sformatf("reset_outputs_dut%0d", w), {bz, dn, e, g, l}, 5'b0);
        end
        @(negedge clk);
        rst = 1'b0;
        tick();

        // ---------------- table-driven vectors ----------------
        for (int i = 0; i < vecs.size(); i++) begin
            run_cmp(vecs[i], $sformatf("vec%0d", i));
        end

        // ---------------- result hold for 10 idle cycles ----------------
        run_cmp(vecs[0], "hold_setup");
        for (int c = 0; c < 10; c++) begin
            tick();
            sample(0, bz, dn, e, g, l);
            check($sformatf("hold_cycle%0d", c), {bz, dn, e, g, l}, 5'b00100);
        end

        // ---------------- start held high, operands change during RUN ----------------
        @(negedge clk);
        drive(0, 1'b1, 8'h0F, 8'h0F, 1'b1);
        tick();
        drive(0, 1'b1, 8'hFF, 8'h00, 1'b1);
        edges = 1;
        sample(0, bz, dn, e, g, l);
        while (!dn && edges < 40) begin
            tick();
            edges++;
            sample(0, bz, dn, e, g, l);
        end
        check("held_start_latency", edges, 5);
        check("held_start_first_flags", {e, g, l}, 3'b100);
        tick();
        sample(0, bz, dn, e, g, l);
        check("held_start_idle_gap", {bz, dn, e, g, l}, 5'b00100);
        tick();
        sample(0, bz, dn, e, g, l);
        check("held_start_reaccept", {bz, dn, e, g, l}, 5'b10000);
        drive(0, 1'b0, 8'h00, 8'h00, 1'b0);
        tick();
        sample(0, bz, dn, e, g, l);
        check("held_start_second_result", {bz, dn, e, g, l}, 5'b01010);
        tick();

        // ---------------- reset during RUN ----------------
        run_cmp(vecs[0], "pre_reset_eq");
        @(negedge clk);
        drive(0, 1'b1, 8'h33, 8'h30, 1'b1);
        tick();
        drive(0, 1'b0, 8'h00, 8'h00, 1'b0);
        tick();
        sample(0, bz, dn, e, g, l);
        check("reset_mid_run_busy_before", bz, 1'b1);
        rst = 1'b1;
        tick();
        sample(0, bz, dn, e, g, l);
        check("reset_mid_run_outputs", {bz, dn, e, g, l}, 5'b0);
        rst = 1'b0;
        saw_done = 1'b0;
        for (int c = 0; c < 8; c++) begin
            tick();
            sample(0, bz, dn, e, g, l);
            if (dn || bz) saw_done = 1'b1;
        end
        check("reset_mid_run_no_done", saw_done, 1'b0);
        run_cmp(vec_t'{0, 8'h33, 8'h30, 1'b1, 5, 1'b0, 1'b1, 1'b0}, "after_reset");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_serial_digit_comparator
